// File: rtl/counter_arbiter_if.sv
// Bus between counter_arbiter and its two requesters plus the shared mod-8 counter.
interface counter_arbiter_if;
    // Handshake: a requester holds reqN high (level) to ask for one counting run.
    // The arbiter answers with gntN from the cycle after the grant edge through
    // the DONE cycle. lenN is sampled only on the grant edge. doneN pulses for
    // exactly one cycle when the run ends (err alongside it for a watchdog
    // abort), and gntN drops on the following edge. Dropping reqN mid-run does
    // not cancel the run. en tells the shared counter to step by one on the
    // next clk edge.
    logic       req0;
    logic       req1;
    logic [2:0] len0;
    logic [2:0] len1;
    logic [2:0] num;
    logic       en;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic       err;
    logic       busy;
    logic [1:0] state_dbg;
    logic [3:0] wdog_dbg;
    logic [2:0] start_dbg;

    modport slave (
        input  req0, req1, len0, len1, num,
        output en, gnt0, gnt1, done0, done1, err, busy,
        output state_dbg, wdog_dbg, start_dbg
    );

    modport master (
        output req0, req1, len0, len1, num,
        input  en, gnt0, gnt1, done0, done1, err, busy,
        input  state_dbg, wdog_dbg, start_dbg
    );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin owner of a shared mod-8 counter. A granted requester gets a run
// of len counts; the block drives en until the counter reaches start+len, then
// pulses done. A watchdog ends runs whose counter never reaches the target.
module counter_arbiter (
    input  logic             clk,
    input  logic             reset,
    counter_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ninth RUN cycle: the watchdog gives up at the edge that ends it.
    localparam logic [3:0] WDOG_LAST = 4'd8;

    state_t     state_q;
    state_t     state_n;
    logic       gnt0_q, gnt0_n;
    logic       gnt1_q, gnt1_n;
    logic       done0_q, done0_n;
    logic       done1_q, done1_n;
    logic       err_q, err_n;
    logic       busy_q, busy_n;
    logic       last_q, last_n;
    logic [2:0] target_q, target_n;
    logic [2:0] start_q, start_n;
    logic [3:0] wdog_q, wdog_n;
    logic       pick;
    logic [2:0] len_w;
    logic [2:0] num_inc;
    logic       hit;
    logic       en_c;

    // Counter value after one more enabled edge; the run ends on the edge that lands on target.
    assign num_inc = bus.num + 3'd1;

    // Next-state, arbitration and registered-output values for the coming edge.
    always_comb begin
        state_n  = state_q;
        gnt0_n   = gnt0_q;
        gnt1_n   = gnt1_q;
        done0_n  = 1'b0;
        done1_n  = 1'b0;
        err_n    = 1'b0;
        last_n   = last_q;
        target_n = target_q;
        start_n  = start_q;
        wdog_n   = wdog_q;
        pick     = 1'b0;
        len_w    = 3'd0;
        hit      = 1'b0;
        en_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie the requester that was not granted last wins.
                    pick     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    len_w    = pick ? bus.len1 : bus.len0;
                    gnt0_n   = ~pick;
                    gnt1_n   = pick;
                    last_n   = pick;
                    start_n  = bus.num;
                    target_n = bus.num + len_w;
                    wdog_n   = 4'd0;
                    if (len_w == 3'd0) begin
                        // Nothing to count: report completion straight away.
                        state_n = DONE;
                        done0_n = ~pick;
                        done1_n = pick;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                en_c   = (bus.num != target_q);
                wdog_n = wdog_q + 4'd1;
                hit    = (bus.num == target_q) || (num_inc == target_q);
                if (hit) begin
                    state_n = DONE;
                    done0_n = gnt0_q;
                    done1_n = gnt1_q;
                end else if (wdog_q == WDOG_LAST) begin
                    state_n = DONE;
                    done0_n = gnt0_q;
                    done1_n = gnt1_q;
                    err_n   = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                gnt0_n  = 1'b0;
                gnt1_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                gnt0_n  = 1'b0;
                gnt1_n  = 1'b0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and registered outputs; reset drops everything without waiting for clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            last_q   <= 1'b1;
            target_q <= 3'd0;
            start_q  <= 3'd0;
            wdog_q   <= 4'd0;
        end else begin
            state_q  <= state_n;
            gnt0_q   <= gnt0_n;
            gnt1_q   <= gnt1_n;
            done0_q  <= done0_n;
            done1_q  <= done1_n;
            err_q    <= err_n;
            busy_q   <= busy_n;
            last_q   <= last_n;
            target_q <= target_n;
            start_q  <= start_n;
            wdog_q   <= wdog_n;
        end
    end

    assign bus.en        = en_c;
    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.state_dbg = state_q;
    assign bus.wdog_dbg  = wdog_q;
    assign bus.start_dbg = start_q;
endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: directed scenarios plus a random run, all checked
// cycle by cycle against a run-schedule model kept in exp_q.
module tb_counter_arbiter;
    logic clk;
    logic reset;
    counter_arbiter_if bus ();

    counter_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         total;
    int         bad;
    logic       cnt_on;
    logic       m_last;
    logic [6:0] exp_q[$];

    // Clock and global time bound.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench time limit");
    end

    // Packed view of the outputs: {en, gnt0, gnt1, done0, done1, err, busy}.
    function automatic logic [6:0] mk(input logic en, input logic g0, input logic g1,
                                      input logic d0, input logic d1, input logic e,
                                      input logic b);
        return {en, g0, g1, d0, d1, e, b};
    endfunction

    // Model: on a grant, schedule the whole run as one entry per cycle.
    task automatic model_arb(input logic r0, input logic r1, input logic [2:0] l0,
                             input logic [2:0] l1);
        logic       pick;
        logic [2:0] l;
        int         n;
        if (r0 || r1) begin
            pick   = (r0 && r1) ? ~m_last : r1;
            m_last = pick;
            l      = pick ? l1 : l0;
            if (l == 3'd0) n = 0;
            else if (cnt_on) n = int'(l);
            else n = 9;
            for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b1, ~pick, pick, 1'b0, 1'b0, 1'b0, 1'b1));
            exp_q.push_back(mk(1'b0, ~pick, pick, ~pick, pick, (n == 9), 1'b1));
        end
    endtask

    // Driver: advance one cycle, step the bench counter, drive inputs, sample outputs.
    task automatic cycle(input logic r0, input logic r1, input logic [2:0] l0,
                         input logic [2:0] l1, output logic [6:0] obs,
                         output logic [6:0] exp_v);
        logic en_pre;
        @(negedge clk);
        en_pre = bus.en;
        @(posedge clk);
        #1;
        if (cnt_on && en_pre) bus.num = bus.num + 3'd1;
        bus.req0 = r0;
        bus.req1 = r1;
        bus.len0 = l0;
        bus.len1 = l1;
        #1;
        obs = {bus.en, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.busy};
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
        end else begin
            exp_v = 7'b0;
            model_arb(r0, r1, l0, l1);
        end
    endtask

    task automatic test_reset();
        logic [6:0] o;
        logic [6:0] e;
        int         guard;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.len0 = 3'd0; bus.len1 = 3'd0; bus.num = 3'd0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #2;
        o = {bus.en, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.busy};
        total++;
        if (o !== 7'b0) begin bad++; $display("FAIL reset_outputs: got %b want %b", o, 7'b0); end
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b0, 1'b0, 3'd0, 3'd0, o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL reset_idle: got %b want %b", o, e); end
        // First tie after reset goes to requester 0.
        cycle(1'b1, 1'b1, 3'd1, 3'd1, o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL reset_tie_arb: got %b want %b", o, e); end
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            cycle(1'b0, 1'b0, 3'd0, 3'd0, o, e);
            total++;
            if (o !== e) begin bad++; $display("FAIL reset_tie_run: got %b want %b", o, e); end
            guard++;
        end
    endtask

    task automatic test_single_run();
        logic [6:0] o;
        logic [6:0] e;
        int         guard, en_cnt, done_cnt, err_cnt;
        cnt_on = 1'b1;
        bus.num = 3'd0;
        en_cnt = 0; done_cnt = 0; err_cnt = 0;
        cycle(1'b1, 1'b0, 3'd5, 3'd0, o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL single_grant: got %b want %b", o, e); end
        guard = 0;
        // Request dropped and len changed after the grant: run must be unaffected.
        while (exp_q.size() > 0 && guard < 20) begin
            cycle(1'b0, 1'b0, 3'd1, 3'd0, o, e);
            total++;
            if (o !== e) begin bad++; $display("FAIL single_cycle: got %b want %b", o, e); end
            en_cnt += int'(o[6]); done_cnt += int'(o[3]); err_cnt += int'(o[1]);
            guard++;
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL single_bound: got %0d left want 0", exp_q.size()); end
        total++;
        if (en_cnt != 5) begin bad++; $display("FAIL single_en_count: got %0d want 5", en_cnt); end
        total++;
        if (bus.num !== 3'd5) begin bad++; $display("FAIL single_num_end: got %0d want 5", bus.num); end
        total++;
        if (done_cnt != 1 || err_cnt != 0) begin
            bad++; $display("FAIL single_done: got done=%0d err=%0d want 1 0", done_cnt, err_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [6:0] o;
        logic [6:0] e;
        int         guard, en_cnt, done_cnt;
        bus.num = 3'd6;
        en_cnt = 0; done_cnt = 0;
        cycle(1'b0, 1'b1, 3'd0, 3'd3, o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL wrap_grant: got %b want %b", o, e); end
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            cycle(1'b0, 1'b0, 3'd0, 3'd7, o, e);
            total++;
            if (o !== e) begin bad++; $display("FAIL wrap_cycle: got %b want %b", o, e); end
            en_cnt += int'(o[6]); done_cnt += int'(o[2]);
            guard++;
        end
        total++;
        if (en_cnt != 3) begin bad++; $display("FAIL wrap_en_count: got %0d want 3", en_cnt); end
        total++;
        if (bus.num !== 3'd1) begin bad++; $display("FAIL wrap_num_end: got %0d want 1", bus.num); end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL wrap_done1: got %0d want 1", done_cnt); end
        cycle(1'b0, 1'b0, 3'd0, 3'd0, o, e);
        total++;
        if (o !== 7'b0) begin bad++; $display("FAIL wrap_idle_after: got %b want %b", o, 7'b0); end
    endtask

    task automatic test_fairness();
        logic [6:0] o;
        logic [6:0] e;
        logic       prev0, prev1;
        int         got_q[$];
        int         guard;
        prev0 = 1'b0; prev1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b1, 3'd2, 3'd1, o, e);
            total++;
            if (o !== e) begin bad++; $display("FAIL fair_cycle: got %b want %b", o, e); end
            total++;
            if (o[5] && o[4]) begin bad++; $display("FAIL fair_overlap: got gnt=11 want one-hot"); end
            if (o[5] && !prev0) got_q.push_back(0);
            if (o[4] && !prev1) got_q.push_back(1);
            prev0 = o[5]; prev1 = o[4];
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            cycle(1'b0, 1'b0, 3'd0, 3'd0, o, e);
            total++;
            if (o !== e) begin bad++; $display("FAIL fair_drain: got %b want %b", o, e); end
            guard++;
        end
        total++;
        if (got_q.size() < 4) begin bad++; $display("FAIL fair_grants: got %0d want >=4", got_q.size()); end
        for (int k = 0; k < 4; k++) begin
            if (k < got_q.size()) begin
                total++;
                if (got_q[k] != (k % 2)) begin
                    bad++; $display("FAIL fair_order[%0d]: got %0d want %0d", k, got_q[k], k % 2);
                end
            end
        end
    endtask

    task automatic test_zero_len();
        logic [6:0] o;
        logic [6:0] e;
        logic [2:0] saved;
        int         guard, en_cnt, done_cnt;
        saved = bus.num;
        en_cnt = 0; done_cnt = 0;
        cycle(1'b1, 1'b0, 3'd0, 3'd0, o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL zero_grant: got %b want %b", o, e); end
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            cycle(1'b0, 1'b0, 3'd0, 3'd0, o, e);
            total++;
            if (o !== e) begin bad++; $display("FAIL zero_cycle: got %b want %b", o, e); end
            en_cnt += int'(o[6]); done_cnt += int'(o[3]);
            guard++;
        end
        total++;
        if (en_cnt != 0 || done_cnt != 1) begin
            bad++; $display("FAIL zero_pulses: got en=%0d done=%0d want 0 1", en_cnt, done_cnt);
        end
        total++;
        if (bus.num !== saved) begin bad++; $display("FAIL zero_num: got %0d want %0d", bus.num, saved); end
    endtask

    task automatic test_watchdog();
        logic [6:0] o;
        logic [6:0] e;
        logic [2:0] saved;
        int         guard, en_cnt, both_cnt;
        cnt_on = 1'b0;
        saved = bus.num;
        en_cnt = 0; both_cnt = 0;
        cycle(1'b1, 1'b0, 3'd4, 3'd0, o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL wdog_grant: got %b want %b", o, e); end
        guard = 0;
        while (exp_q.size() > 0 && guard < 30) begin
            cycle(1'b0, 1'b0, 3'd4, 3'd0, o, e);
            total++;
            if (o !== e) begin bad++; $display("FAIL wdog_cycle: got %b want %b", o, e); end
            en_cnt += int'(o[6]); both_cnt += int'(o[3] & o[1]);
            guard++;
        end
        total++;
        if (en_cnt != 9) begin bad++; $display("FAIL wdog_en_count: got %0d want 9", en_cnt); end
        total++;
        if (both_cnt != 1) begin bad++; $display("FAIL wdog_done_err: got %0d want 1", both_cnt); end
        total++;
        if (bus.num !== saved) begin bad++; $display("FAIL wdog_num: got %0d want %0d", bus.num, saved); end
        cnt_on = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        logic [6:0] o;
        logic [6:0] e;
        int         guard, en_cnt, done_cnt;
        bus.num = 3'd3;
        cycle(1'b1, 1'b0, 3'd6, 3'd0, o, e);
        total++;
        if (o !== e) begin bad++; $display("FAIL rmid_grant: got %b want %b", o, e); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 3'd6, 3'd0, o, e);
            total++;
            if (o !== e) begin bad++; $display("FAIL rmid_en: got %b want %b", o, e); end
        end
        // Third en cycle: pull reset between edges.
        #1;
        reset = 1'b0;
        #1;
        o = {bus.en, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.busy};
        total++;
        if (o !== 7'b0) begin bad++; $display("FAIL rmid_async: got %b want %b", o, 7'b0); end
        total++;
        if (bus.num !== 3'd5) begin bad++; $display("FAIL rmid_num_hold: got %0d want 5", bus.num); end
        exp_q.delete();
        m_last = 1'b1;
        reset = 1'b1;
        model_arb(1'b1, 1'b0, 3'd6, 3'd0);
        en_cnt = 0; done_cnt = 0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            cycle(1'b0, 1'b0, 3'd0, 3'd0, o, e);
            total++;
            if (o !== e) begin bad++; $display("FAIL rmid_fresh: got %b want %b", o, e); end
            en_cnt += int'(o[6]); done_cnt += int'(o[3]);
            guard++;
        end
        total++;
        if (en_cnt != 6 || done_cnt != 1) begin
            bad++; $display("FAIL rmid_fresh_count: got en=%0d done=%0d want 6 1", en_cnt, done_cnt);
        end
        total++;
        if (bus.num !== 3'd3) begin bad++; $display("FAIL rmid_num_end: got %0d want 3", bus.num); end
    endtask

    task automatic test_random();
        logic [6:0] o;
        logic [6:0] e;
        logic       r0, r1;
        logic [2:0] l0, l1;
        int         guard;
        for (int i = 0; i < 300; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            l0 = 3'($urandom_range(0, 7));
            l1 = 3'($urandom_range(0, 7));
            cycle(r0, r1, l0, l1, o, e);
            total++;
            if (o !== e) begin bad++; $display("FAIL rand_cycle[%0d]: got %b want %b", i, o, e); end
            total++;
            if (o[5] && o[4]) begin bad++; $display("FAIL rand_overlap[%0d]: got gnt=11 want one-hot", i); end
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            cycle(1'b0, 1'b0, 3'd0, 3'd0, o, e);
            total++;
            if (o !== e) begin bad++; $display("FAIL rand_drain: got %b want %b", o, e); end
            guard++;
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL rand_bound: got %0d left want 0", exp_q.size()); end
    endtask

    // Scenario sequence and final report.
    initial begin
        total  = 0;
        bad    = 0;
        cnt_on = 1'b1;
        m_last = 1'b1;
        test_reset();
        test_single_run();
        test_wrap();
        test_fairness();
        test_zero_len();
        test_watchdog();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately, release is synchronised by the next clk edge.
REQ-003 req0, req1  input  1 each  level request from requester 0/1 for one counting run.
REQ-004 len0, len1  input  3 each  run length in counts (0..7) for requester 0/1; sampled only at grant.
REQ-005 num  input  3  current value of the shared mod-8 counter the block sequences.
REQ-006 en  output  1  count enable to the shared counter; counter increments by 1 (mod 8) on each clk edge where en=1.
REQ-007 gnt0, gnt1  output  1 each  one-hot ownership of the counter; at most one high.
REQ-008 done0, done1  output  1 each  single-cycle run-complete pulse to the owning requester.
REQ-009 err  output  1  single-cycle pulse, coincident with done, when the run was terminated by the watchdog.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE (3 states, 2-bit encoding).
REQ-012 In IDLE with any req high at a clk edge, the block SHALL select a winner, register gnt, capture start=num and target=(num+len_winner) mod 8 (3-bit wrap), clear the watchdog and go to RUN.
REQ-013 Arbitration SHALL be round-robin: with a single requester it wins; with both high, the requester not granted last wins; last-grant pointer resets to 1 so req0 wins the first tie.
REQ-014 len of the winner equal to 0 SHALL take IDLE directly to DONE; en is never asserted for that run.
REQ-015 In RUN, en SHALL equal (num != target); en is the only combinational output.
REQ-016 RUN SHALL go to DONE at the edge where num == target; for len=L the counter SHALL receive exactly L enabled edges, wrap past 7->0 included (e.g. start 6, len 3 -> target 1).
REQ-017 A 4-bit watchdog SHALL count RUN cycles; on reaching 9 with num != target, the block SHALL go to DONE and raise err with done.
REQ-018 DONE SHALL last exactly one cycle: done of the owner high, gnt held, en low; next state IDLE with gnt cleared.
REQ-019 Deasserting req during RUN SHALL NOT abort the run; len changes after grant SHALL be ignored.
REQ-020 A requester still holding req at DONE SHALL be rearbitrated in the following IDLE cycle, so minimum spacing between runs is one IDLE cycle.
REQ-021 Latency: req sampled at edge k in IDLE -> gnt high from cycle k+1, first en cycle k+1, done in cycle k+1+L (L>0).
REQ-022 gnt0 and gnt1 SHALL never be high together, and done/err SHALL never be high outside DONE.

Reset
REQ-023 reset=0 SHALL force state=IDLE, en=0, gnt0=gnt1=0, done0=done1=0, err=0, busy=0, last-grant=1, target=0, watchdog=0 without waiting for clk.
REQ-024 reset asserted mid-RUN SHALL drop en and gnt in the same cycle; no done pulse is produced for the aborted run.

Verification
REQ-025 Single run: num=0, req0=1, len0=5 -> gnt0 next cycle, en high 5 cycles, num ends 5, done0 one cycle, err=0.
REQ-026 Wrap: num=6, req1=1, len1=3 -> en 3 cycles, num 6->7->0->1, done1 pulse, then IDLE.
REQ-027 Tie and fairness: req0=req1=1 held, len0=2, len1=1 -> grants alternate 0,1,0,1 with one IDLE cycle between runs; gnt never overlapping.
REQ-028 Zero length: req0=1, len0=0 -> IDLE->DONE, done0 pulse, en never high, num unchanged.
REQ-029 Watchdog: num held constant (counter disconnected), req0=1, len0=4 -> en high 9 cycles, then done0 and err pulse together.
REQ-030 Reset mid-run: reset=0 during third en cycle of len 6 run -> en, gnt0, busy low immediately; after release, req0 still high -> req0 granted and a fresh run starts from current num.
